// File: rtl/mips_immediate_expand_stage.sv
// mips_immediate_expand_stage
//
// Elastic pipeline stage between decode and execute. It expands the 16-bit
// instruction immediate into a 32-bit operand, using the extend/shift control
// fields produced upstream. A 2-entry skid buffer sustains full throughput
// under downstream backpressure and keeps in_ready purely registered.
//
// Ports:
//   clock      - single clock; all state updates on the rising edge
//   reset_n    - asynchronous, active-low reset
//   flush      - synchronous squash of all held entries
//   in_valid   - upstream presents an entry
//   in_ready   - stage can accept (registered; low only when both slots are full)
//   in_imm     - raw 16-bit immediate field
//   in_extend  - 0 = sign extend, 1 = zero extend
//   in_shift   - 0 = no shift, 1 = place immediate in the upper half (LUI)
//   in_tag     - opaque tag, passed through unchanged
//   out_valid  - output entry valid
//   out_ready  - downstream accepts
//   out_imm    - expanded 32-bit immediate
//   out_tag    - tag belonging to out_imm

module mips_immediate_expand_stage #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_imm,
    input  logic             in_extend,
    input  logic             in_shift,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_imm,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               in_ready_q;

    logic [31:0]        main_imm_q;
    logic [TAG_W-1:0]   main_tag_q;
    logic [31:0]        skid_imm_q;
    logic [TAG_W-1:0]   skid_tag_q;

    logic [31:0]        expanded;
    logic               push;
    logic               pop;
    logic               load_main_new;
    logic               load_main_skid;
    logic               load_skid;

    // ------------------------------------------------------------------
    // Immediate expansion (combinational on the input side)
    // ------------------------------------------------------------------
    always_comb begin
        if (in_shift) begin
            expanded = {in_imm, 16'h0000};
        end else if (in_extend) begin
            expanded = {16'h0000, in_imm};
        end else begin
            expanded = {{16{in_imm[15]}}, in_imm};
        end
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_imm   = main_imm_q;
    assign out_tag   = main_tag_q;

    // push/pop depend only on the valid/ready bits, so X on the data
    // inputs never reaches the state register.
    assign push = in_valid & in_ready_q;
    assign pop  = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Next-state and data-load decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d       = ONE;
                    load_main_new = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_main_new = 1'b1;
                end else if (push) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so no push can arrive.
                if (pop) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // A flush empties the stage; an entry accepted in the same cycle is
        // discarded, so nothing is loaded. A pop in that cycle has already
        // been seen downstream and simply completes.
        if (flush) begin
            state_d        = EMPTY;
            load_main_new  = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State register; in_ready is registered from the next state so it
    // equals (state != TWO) without a combinational path.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    // ------------------------------------------------------------------
    // Data registers: load only on transfers, hold otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_imm_q <= '0;
            main_tag_q <= '0;
        end else if (load_main_new) begin
            main_imm_q <= expanded;
            main_tag_q <= in_tag;
        end else if (load_main_skid) begin
            main_imm_q <= skid_imm_q;
            main_tag_q <= skid_tag_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            skid_imm_q <= '0;
            skid_tag_q <= '0;
        end else if (load_skid) begin
            skid_imm_q <= expanded;
            skid_tag_q <= in_tag;
        end
    end

endmodule

// File: tb/tb_mips_immediate_expand_stage.sv
module tb_mips_immediate_expand_stage;

    localparam int unsigned TAG_W = 4;

    logic             clock     = 1'b0;
    logic             reset_n   = 1'b0;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [15:0]      in_imm    = '0;
    logic             in_extend = 1'b0;
    logic             in_shift  = 1'b0;
    logic [TAG_W-1:0] in_tag    = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_imm;
    logic [TAG_W-1:0] out_tag;

    mips_immediate_expand_stage #(.TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_extend (in_extend),
        .in_shift  (in_shift),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_tag   (out_tag)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0]      imm;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t        sb[$];
    int unsigned n_checks   = 0;
    int unsigned n_fail     = 0;
    int unsigned n_accept   = 0;
    logic        pushed_now = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the operand as an integer value.
    function automatic logic [31:0] model(input logic [15:0] imm, input logic ext, input logic sh);
        longint v;
        v = longint'(imm);
        if (sh) begin
            v = v * 65536;
        end else if (!ext && v >= 32768) begin
            v = v - 65536;
        end
        return 32'(v);
    endfunction

    // One clock of stimulus. Inputs change 1 time unit after the rising edge;
    // acceptance is decided at the falling edge and recorded in the scoreboard.
    task automatic drive(input logic v, input logic [15:0] imm, input logic ext, input logic sh,
                         input logic [TAG_W-1:0] tag, input logic ordy, input logic fl,
                         input logic use_exp, input logic [31:0] exp);
        ent_t e;
        in_valid  = v;
        in_imm    = imm;
        in_extend = ext;
        in_shift  = sh;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        @(negedge clock);
        pushed_now = in_valid && in_ready && reset_n && !flush;
        if (in_valid && in_ready && reset_n) n_accept++;
        if (pushed_now) begin
            e.imm = use_exp ? exp : model(imm, ext, sh);
            e.tag = tag;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic ordy, input logic fl);
        drive(1'b0, 16'hxxxx, 1'bx, 1'bx, '0, ordy, fl, 1'b0, '0);
    endtask

    task automatic push_rand(input logic [TAG_W-1:0] tag, input logic ordy);
        drive(1'b1, 16'($urandom), 1'($urandom), 1'($urandom), tag, ordy, 1'b0, 1'b0, '0);
    endtask

    // Monitor: occupancy and FIFO-order data checks, decoupled from stimulus.
    initial begin
        int exp_cnt;
        ent_t e;
        forever begin
            @(negedge clock);
            #1;
            if (reset_n) begin
                exp_cnt = sb.size() - (pushed_now ? 1 : 0);
                check("out_valid", 64'(out_valid), 64'(exp_cnt != 0));
                check("in_ready", 64'(in_ready), 64'(exp_cnt < 2));
                if (out_valid && out_ready) begin
                    if (exp_cnt == 0) begin
                        check("unexpected_pop", 64'(1), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        check("out_imm", 64'(out_imm), 64'(e.imm));
                        check("out_tag", 64'(out_tag), 64'(e.tag));
                    end
                end
                if (flush) begin
                    sb.delete();
                    pushed_now = 1'b0;
                end
            end
        end
    end

    initial begin
        int unsigned budget;
        repeat (3) @(posedge clock);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_imm", 64'(out_imm), 64'(0));
        reset_n = 1'b1;
        idle(1'b1, 1'b0);

        // Expansion corner cases with literal expectations.
        drive(1'b1, 16'h8000, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 32'hFFFF8000);
        drive(1'b1, 16'h8000, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 32'h00008000);
        drive(1'b1, 16'h1234, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 32'h12340000);
        drive(1'b1, 16'h1234, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 32'h12340000);
        drive(1'b1, 16'h7FFF, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1, 32'h00007FFF);
        idle(1'b1, 1'b0);

        // Streaming: tags 0..9 back to back with out_ready high.
        for (int i = 0; i < 10; i++) push_rand(TAG_W'(i), 1'b1);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        // Backpressure: only two entries fit.
        n_accept = 0;
        for (int i = 0; i < 5; i++) push_rand(TAG_W'(1 + n_accept), 1'b0);
        check("bp_accepted", 64'(n_accept), 64'(2));
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);

        // Simultaneous push/pop while holding one entry.
        push_rand(4'd6, 1'b0);
        push_rand(4'd7, 1'b1);
        push_rand(4'd8, 1'b1);
        idle(1'b1, 1'b0);

        // Flush while full with in_valid high, then a fresh push.
        push_rand(4'd1, 1'b0);
        push_rand(4'd2, 1'b0);
        drive(1'b1, 16'h5555, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, '0);
        push_rand(4'd5, 1'b1);
        idle(1'b1, 1'b0);
        // Flush with a pop and a push in the same cycle (state ONE).
        push_rand(4'd9, 1'b0);
        drive(1'b1, 16'hAAAA, 1'b1, 1'b0, 4'd10, 1'b1, 1'b1, 1'b0, '0);
        idle(1'b1, 1'b0);

        // Asynchronous reset while full, between clock edges.
        push_rand(4'd11, 1'b0);
        push_rand(4'd12, 1'b0);
        idle(1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'(0));
        check("async_rst_in_ready", 64'(in_ready), 64'(1));
        check("async_rst_out_imm", 64'(out_imm), 64'(0));
        check("async_rst_out_tag", 64'(out_tag), 64'(0));
        sb.delete();
        pushed_now = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(1'b1, 1'b0);
        push_rand(4'd13, 1'b1);
        idle(1'b1, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom), 1'($urandom),
                  TAG_W'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 29) == 0), 1'b0, '0);
        end

        // Drain with a bounded budget.
        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            idle(1'b1, 1'b0);
            budget++;
        end
        check("drain_empty", 64'(sb.size()), 64'(0));
        idle(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_immediate_expand_stage.md
Name: mips_immediate_expand_stage

Overview:
- Consumer end of the immediate control interface. Takes the 16-bit instruction immediate plus the extend/shift control fields, which are produced upstream in decode, and produces the 32-bit operand value.
- Sits between decode and execute as an elastic pipeline stage with valid/ready on both sides.
- Includes a 2-entry skid buffer, so full throughput is sustained under downstream backpressure and in_ready is purely registered.

Parameters:
- TAG_W, 4, width of the opaque instruction tag carried alongside each immediate (pipeline slot / ROB id).

Ports:
- clock  input  1  single clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous squash of all held entries (branch/exception redirect)
- in_valid  input  1  upstream has an entry
- in_ready  output  1  stage can accept; registered, equals (state != TWO)
- in_imm  input  16  raw instruction immediate field
- in_extend  input  1  0 = Signed extend, 1 = Unsigned (zero) extend
- in_shift  input  1  0 = None, 1 = Left16 (LUI)
- in_tag  input  TAG_W  tag, passed through unchanged
- out_valid  output  1  output entry valid
- out_ready  input  1  downstream accepts
- out_imm  output  32  expanded immediate
- out_tag  output  TAG_W  tag of out_imm

Behaviour:
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Expansion is combinational on input and registered into storage.
  - shift = Left16: value = {in_imm, 16'h0000}. in_extend is ignored.
  - shift = None, extend = Signed: value = {{16{in_imm[15]}}, in_imm}.
  - shift = None, extend = Unsigned: value = {16'h0000, in_imm}.
- Storage:
  - main register drives out_imm/out_tag.
  - skid register holds a second entry.
  - FSM states: EMPTY, ONE, TWO.
- Transitions:
  - EMPTY: push -> ONE; main <= new entry.
  - ONE, push & pop -> ONE; main <= new entry.
  - ONE, push & !pop -> TWO; skid <= new entry; main is held.
  - ONE, !push & pop -> EMPTY.
  - ONE, neither -> ONE.
  - TWO: in_ready = 0, so push is impossible. pop -> ONE; main <= skid. No pop -> hold.
- out_valid = (state != EMPTY).
- Latency: an entry accepted in cycle N is presented with out_valid in cycle N+1 when the stage was empty or popping. Throughput is 1 entry/cycle while out_ready = 1.
- Ordering is strictly FIFO. No entry is ever duplicated or dropped except by flush.
- out_imm/out_tag hold their value while out_valid = 1 and out_ready = 0, and do not change until pop.
- flush:
  - Next state is EMPTY, regardless of push/pop in the same cycle.
  - An input accepted in the flush cycle is discarded.
  - A pop in the flush cycle still completes downstream, because out_valid was already high.
  - in_ready = 1 in the cycle after flush.
- Reset (asserted at any time, including mid-transfer):
  - state = EMPTY, out_valid = 0, in_ready = 1.
  - out_imm = 32'h0, out_tag = 0, skid contents = 0.
  - Release is synchronous to clock through the design's standard reset synchroniser. The block only requires asynchronous assertion.
- Data registers load only on the transitions above, not on idle cycles. This avoids toggling on stale inputs.
- Inputs are don't-care when in_valid = 0. X on in_imm must not propagate to out_valid or state.

Test Plan:
- Expansion:
  - imm 16'h8000, Signed, None -> out_imm 32'hFFFF8000.
  - Same imm, Unsigned -> 32'h00008000.
  - imm 16'h1234, Left16, either extend -> 32'h12340000.
  - imm 16'h7FFF, Signed -> 32'h00007FFF.
- Streaming:
  - out_ready = 1; tags 0..9 pushed back-to-back.
  - out_valid rises 1 cycle after the first push.
  - Tags 0..9 appear on 10 consecutive cycles; in_ready stays 1.
- Backpressure:
  - out_ready = 0, continuous in_valid.
  - Exactly 2 entries accepted (tags 1, 2); in_ready = 0 from the following cycle.
  - Raising out_ready drains 1 then 2 in order, with in_ready = 1 one cycle after the first pop.
- Simultaneous push/pop in ONE:
  - State stays ONE.
  - out_imm updates to the new entry the next cycle; no bubble.
- Flush in TWO with in_valid = 1:
  - out_valid = 0 next cycle, in_ready = 1.
  - The flushed tags never appear; a subsequent push (tag 5) appears 1 cycle later.
- Reset mid-operation:
  - Assert reset_n = 0 asynchronously in TWO, between clock edges.
  - out_valid = 0, in_ready = 1, out_imm = 0 immediately.
  - After release, normal operation resumes with no stale entry.
